// File: rtl/serial_reader_pkg.sv
// Shared definitions for the serial writer/reader pair: frame geometry and
// the reader's state encoding.
package serial_reader_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_CWIDTH = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serial_reader_if.sv
// Valid/ready word channel from the serial reader to its consumer.
interface serial_reader_if #(
  parameter int width = 64
);

  logic [width-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/serial_reader.sv
// Serial-in, parallel-out reader: captures mosi LSB first on enabled sclk
// edges and offers each completed word on a valid/ready channel.
module serial_reader
  import serial_reader_pkg::*;
#(
  parameter int width  = DEF_WIDTH,
  parameter int cwidth = DEF_CWIDTH
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             mosi,
  output logic             busy,
  output logic             overrun,
  serial_reader_if.master  out_if
);

  state_e             state_q, state_d;
  logic [cwidth-1:0]  idx_q, idx_d;
  logic [width-1:0]   shreg_q, shreg_d;
  logic [width-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               complete;

  // NOTE: every variable gets a default before any branch so this block can
  // never infer a latch; blocking '=' is correct here because it is combinational.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;

    if (valid_q && out_if.data_ready) begin
      valid_d = 1'b0;
    end

    if (start) begin
      // Restart wins over a same-cycle enable; the stale partial word is dropped.
      state_d = SHIFT;
      idx_d   = '0;
      shreg_d = '0;
    end else if (state_q == SHIFT && enable) begin
      shreg_d[idx_q] = mosi;
      idx_d          = idx_q + cwidth'(1);
      if (idx_q == cwidth'(width - 1)) begin
        complete = 1'b1;
        state_d  = IDLE;
        idx_d    = '0;
      end
    end

    if (complete) begin
      if (!valid_q || out_if.data_ready) begin
        dout_d  = shreg_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d == SHIFT);
  end

  // NOTE: sequential state uses non-blocking '<=' only; the synchronous reset
  // clears the capture register too so a mid-frame reset leaves no residue.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_if.data_out   = dout_q;
  assign out_if.data_valid = valid_q;
  assign busy              = busy_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_serial_reader.sv
// Directed bench for serial_reader: a behavioural writer feeds mosi, frame
// records drive a table loop, and hand sequences cover restart and reset.
module tb_serial_reader;

  localparam int W = 64;

  logic        sclk = 1'b0;
  logic        reset;
  logic        start;
  logic        enable;
  logic        mosi;
  logic        busy;
  logic        overrun;
  logic [W-1:0] data_init;
  logic [W-1:0] wr_q;

  int total = 0;
  int bad   = 0;

  serial_reader_if #(.width(W)) rd_if ();

  serial_reader #(.width(W), .cwidth(6)) dut (
    .sclk    (sclk),
    .reset   (reset),
    .start   (start),
    .enable  (enable),
    .mosi    (mosi),
    .busy    (busy),
    .overrun (overrun),
    .out_if  (rd_if)
  );

  always #5 sclk = ~sclk;

  // Writer model: load_data tied to start, shifts out LSB first on enable.
  always @(posedge sclk) begin
    if (start)       wr_q <= data_init;
    else if (enable) wr_q <= wr_q >> 1;
  end
  assign mosi = wr_q[0];

  typedef struct {
    logic [W-1:0] word;
    int           duty;
    logic         ready_last;
    logic         exp_pre_valid;
    logic [W-1:0] exp_dout;
    logic         exp_valid;
    logic         exp_overrun;
  } frame_t;

  frame_t frames[4];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic start_frame(input logic [W-1:0] word, input logic en);
    data_init = word;
    start     = 1'b1;
    enable    = en;
    step();
    start     = 1'b0;
    enable    = 1'b0;
  endtask

  // Clocks in n enabled bits at roughly duty% enable; data_ready is raised
  // only on the final bit's edge. Valid is checked just before that edge.
  task automatic shift_bits(input int n, input int duty, input logic ready_last,
                            input logic exp_pre_valid, input string tag);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 4000) begin
      enable = ($urandom_range(99) < duty);
      rd_if.data_ready = 1'b0;
      if (enable && cnt == n - 1) begin
        check({tag, "_pre_valid"}, W'(rd_if.data_valid), W'(exp_pre_valid));
        rd_if.data_ready = ready_last;
      end
      step();
      if (enable) cnt++;
      cyc++;
    end
    enable = 1'b0;
    rd_if.data_ready = 1'b0;
    if (cnt < n) check({tag, "_timeout"}, W'(cnt), W'(n));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    enable = 1'b0;
    data_init = '0;
    rd_if.data_ready = 1'b0;

    frames[0] = '{64'h0123_4567_89AB_CDEF, 100, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
    frames[1] = '{64'hDEAD_BEEF_CAFE_F00D, 100, 1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0};
    frames[2] = '{64'hFFFF_0000_FFFF_0000,  30, 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0};
    frames[3] = '{64'h1111_2222_3333_4444,  50, 1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b1};

    step();
    step();
    reset = 1'b0;
    check("rst_dout",    rd_if.data_out,          '0);
    check("rst_valid",   W'(rd_if.data_valid),    '0);
    check("rst_busy",    W'(busy),                '0);
    check("rst_overrun", W'(overrun),             '0);

    // Enable without start must not arm capture.
    enable = 1'b1;
    step(); step();
    enable = 1'b0;
    check("idle_enable_busy", W'(busy), '0);

    foreach (frames[i]) begin
      start_frame(frames[i].word, 1'b0);
      check($sformatf("f%0d_busy_armed", i), W'(busy), 1);
      shift_bits(W, frames[i].duty, frames[i].ready_last, frames[i].exp_pre_valid,
                 $sformatf("f%0d", i));
      check($sformatf("f%0d_dout", i),    rd_if.data_out,       frames[i].exp_dout);
      check($sformatf("f%0d_valid", i),   W'(rd_if.data_valid), W'(frames[i].exp_valid));
      check($sformatf("f%0d_overrun", i), W'(overrun),          W'(frames[i].exp_overrun));
      check($sformatf("f%0d_busy", i),    W'(busy),             '0);
    end

    // Consuming after an overrun clears valid but overrun stays sticky.
    rd_if.data_ready = 1'b1;
    step();
    rd_if.data_ready = 1'b0;
    check("take_valid",   W'(rd_if.data_valid), '0);
    check("take_overrun", W'(overrun),          1);
    check("take_dout",    rd_if.data_out,       64'hFFFF_0000_FFFF_0000);

    // Restart mid-frame with a same-cycle enable.
    start_frame(64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    shift_bits(20, 100, 1'b0, 1'b0, "garbage");
    start_frame(64'h5555_AAAA_5555_AAAA, 1'b1);
    check("restart_busy",  W'(busy),             1);
    check("restart_valid", W'(rd_if.data_valid), '0);
    shift_bits(W, 100, 1'b0, 1'b0, "restart");
    check("restart_dout",    rd_if.data_out,       64'h5555_AAAA_5555_AAAA);
    check("restart_valid2",  W'(rd_if.data_valid), 1);
    check("restart_overrun", W'(overrun),          1);

    // Reset mid-frame.
    start_frame(64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    shift_bits(40, 100, 1'b0, 1'b1, "partial");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_dout",    rd_if.data_out,       '0);
    check("mrst_valid",   W'(rd_if.data_valid), '0);
    check("mrst_busy",    W'(busy),             '0);
    check("mrst_overrun", W'(overrun),          '0);
    enable = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    check("mrst_ignored_busy",  W'(busy),             '0);
    check("mrst_ignored_valid", W'(rd_if.data_valid), '0);
    start_frame(64'hA5A5_5A5A_C3C3_3C3C, 1'b0);
    shift_bits(W, 60, 1'b0, 1'b0, "after_rst");
    check("after_rst_dout",    rd_if.data_out,       64'hA5A5_5A5A_C3C3_3C3C);
    check("after_rst_valid",   W'(rd_if.data_valid), 1);
    check("after_rst_overrun", W'(overrun),          '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
